// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared definitions for the pipeline stall/flush sequencer.
//   - state_t     : sequencer states (RUN / WAIT / ERR)
//   - REG_W_DEF   : default register index width
//   - WAIT_CNT_W  : width of the memory-wait watchdog counter (covers TIMEOUT up to 2^16-1)
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  localparam int REG_W_DEF  = 5;
  localparam int WAIT_CNT_W = 16;

endpackage

// File: rtl/pipe_ctrl_hazard_det.sv
// pipe_hazard_det
//   Pure combinational load-use hazard detector. Flags when the instruction in
//   EX is a load whose destination is a source register of the instruction in ID.
//   Register x0 never creates a hazard.
// Ports
//   i_id_rs1, i_id_rs2           source indices of the ID instruction
//   i_id_rs1_used, i_id_rs2_used source-usage qualifiers
//   i_ex_rd                      destination index of the EX instruction
//   i_ex_is_load                 EX instruction is a load
//   o_lu_stall                   load-use hazard present this cycle
module pipe_hazard_det
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] i_id_rs1,
  input  logic [REG_W-1:0] i_id_rs2,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_is_load,
  output logic             o_lu_stall
);

  logic w_rd_nonzero;
  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rd_nonzero = (i_ex_rd != '0);
  assign w_rs1_hit    = i_id_rs1_used & (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit    = i_id_rs2_used & (i_id_rs2 == i_ex_rd);
  assign o_lu_stall   = i_ex_is_load & w_rd_nonzero & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. Drives PC enable and
//   enable/flush of IF/ID, ID/EX, EX/MEM and MEM/WB. Resolves load-use bubbles,
//   EX-stage redirects and multi-cycle data-memory waits, with a memory-wait
//   watchdog and a saturating stall-cycle counter.
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   id_rs1/id_rs2(_used)     ID-stage source operands
//   ex_rd, ex_is_load        EX-stage destination / load flag
//   ex_redirect              taken branch/jump resolved in EX
//   mem_req, mem_ready       MEM-stage access handshake
//   pc_en, fd_en, fd_flush   PC and IF/ID control
//   de_en, de_flush          ID/EX control
//   em_en, mw_en             EX/MEM and MEM/WB enables
//   mem_timeout              sticky watchdog error
//   stall_cnt                saturating count of cycles with pc_en==0
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W   = REG_W_DEF,
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             fd_en,
  output logic             fd_flush,
  output logic             de_en,
  output logic             de_flush,
  output logic             em_en,
  output logic             mw_en,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_M1 = WAIT_CNT_W'(TIMEOUT - 1);

  state_t                r_state;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic                  r_timeout;
  logic [CNT_W-1:0]      r_stall_cnt;

  logic w_mwait;
  logic w_freeze;
  logic w_lu_stall;

  pipe_hazard_det #(
    .REG_W(REG_W)
  ) u_hazard (
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_rs1_used (id_rs1_used),
    .i_id_rs2_used (id_rs2_used),
    .i_ex_rd       (ex_rd),
    .i_ex_is_load  (ex_is_load),
    .o_lu_stall    (w_lu_stall)
  );

  assign w_mwait  = mem_req & ~mem_ready;
  assign w_freeze = (r_state == ST_ERR) | w_mwait;

  // Zero-latency output mux. Gated by rst so the pipeline is held while reset
  // is asserted even though the FSM itself already sits in RUN.
  always_comb begin
    pc_en    = 1'b0;
    fd_en    = 1'b0;
    fd_flush = 1'b0;
    de_en    = 1'b0;
    de_flush = 1'b0;
    em_en    = 1'b0;
    mw_en    = 1'b0;
    if (rst || w_freeze) begin
      // everything held, redirect and load-use deferred until the freeze ends
    end else if (ex_redirect) begin
      pc_en    = 1'b1;
      fd_en    = 1'b1;
      fd_flush = 1'b1;
      de_en    = 1'b1;
      de_flush = 1'b1;
      em_en    = 1'b1;
      mw_en    = 1'b1;
    end else if (w_lu_stall) begin
      // de_en stays high so the flushed (bubble) value is actually captured
      de_en    = 1'b1;
      de_flush = 1'b1;
      em_en    = 1'b1;
      mw_en    = 1'b1;
    end else begin
      pc_en = 1'b1;
      fd_en = 1'b1;
      de_en = 1'b1;
      em_en = 1'b1;
      mw_en = 1'b1;
    end
  end

  // Sequencer FSM, watchdog and stall counter.
  // r_wait_cnt counts consecutive mwait cycles: the RUN->WAIT cycle loads 1,
  // so the TIMEOUT-th consecutive mwait cycle sees TIMEOUT-1 and trips.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mwait) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= WAIT_CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (!w_mwait) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == TIMEOUT_M1) begin
            r_state   <= ST_ERR;
            r_timeout <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_CNT_W'(1);
          end
        end
        ST_ERR: begin
          r_timeout <= 1'b1;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase

      if (!pc_en && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign mem_timeout = r_timeout;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
//   Directed self-checking bench for pipe_ctrl, built with TIMEOUT=4 and CNT_W=3
//   so watchdog and counter saturation are reachable in a few cycles.
//   Output vector order: {pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mw_en}.
module tb_pipe_ctrl;

  localparam int REG_W   = 5;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 3;

  localparam logic [6:0] O_ZERO = 7'b0000000;
  localparam logic [6:0] O_RUN  = 7'b1101011;
  localparam logic [6:0] O_REDIR = 7'b1111111;
  localparam logic [6:0] O_LU   = 7'b0001111;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic             id_rs1_used, id_rs2_used, ex_is_load, ex_redirect;
  logic             mem_req, mem_ready;
  logic             pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mw_en;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  pipe_ctrl #(
    .REG_W  (REG_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used),
    .ex_rd      (ex_rd),
    .ex_is_load (ex_is_load),
    .ex_redirect(ex_redirect),
    .mem_req    (mem_req),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .fd_en      (fd_en),
    .fd_flush   (fd_flush),
    .de_en      (de_en),
    .de_flush   (de_flush),
    .em_en      (em_en),
    .mw_en      (mw_en),
    .mem_timeout(mem_timeout),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [6:0] exp);
    chk(tag, {25'd0, pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mw_en}, {25'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_is_load = 1'b0; ex_redirect = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    chk_outs("rst_held_outs", O_ZERO);
    chk("rst_held_cnt", 32'(stall_cnt), 32'd0);
    rst = 1'b0;
    #1;
    chk_outs("run_idle", O_RUN);
    chk("run_timeout", 32'(mem_timeout), 32'd0);

    // load-use on rs1
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    #1;
    chk_outs("lu_rs1", O_LU);
    tick();
    chk("lu_rs1_cnt", 32'(stall_cnt), 32'd1);
    // bubble now in EX: hazard gone
    ex_is_load = 1'b0;
    #1;
    chk_outs("lu_cleared", O_RUN);
    tick();
    chk("lu_cleared_cnt", 32'(stall_cnt), 32'd1);

    // load-use on rs2
    ex_is_load = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7;
    id_rs1_used = 1'b1; id_rs2_used = 1'b1;
    #1;
    chk_outs("lu_rs2", O_LU);
    tick();
    chk("lu_rs2_cnt", 32'(stall_cnt), 32'd2);

    // x0 destination never stalls
    ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1;
    #1;
    chk_outs("lu_x0", O_RUN);
    tick();

    // matching but unused source does not stall
    ex_rd = 5'd9; id_rs1 = 5'd2; id_rs2 = 5'd9; id_rs2_used = 1'b0;
    #1;
    chk_outs("lu_unused", O_RUN);
    tick();
    chk("no_stall_cnt", 32'(stall_cnt), 32'd2);

    // redirect beats load-use
    id_rs2_used = 1'b1; ex_redirect = 1'b1;
    #1;
    chk_outs("redir_over_lu", O_REDIR);
    tick();
    chk("redir_cnt", 32'(stall_cnt), 32'd2);
    clear_inputs();

    // async reset mid-cycle, no clock edge in between
    rst = 1'b1;
    #1;
    chk_outs("async_rst_outs", O_ZERO);
    chk("async_rst_cnt", 32'(stall_cnt), 32'd0);
    chk("async_rst_to", 32'(mem_timeout), 32'd0);
    rst = 1'b0;
    tick();

    // memory wait for 3 cycles with redirect held
    mem_req = 1'b1; mem_ready = 1'b0; ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_outs($sformatf("mwait_frozen_%0d", i), O_ZERO);
      tick();
    end
    chk("mwait_cnt", 32'(stall_cnt), 32'd3);
    chk("mwait_no_to", 32'(mem_timeout), 32'd0);
    mem_ready = 1'b1;
    #1;
    chk_outs("mready_redir", O_REDIR);
    tick();
    mem_req = 1'b0; mem_ready = 1'b0; ex_redirect = 1'b0;
    #1;
    chk_outs("back_to_run", O_RUN);
    tick();
    chk("after_mwait_cnt", 32'(stall_cnt), 32'd3);

    // a second 3-cycle wait must not trip: the wait counter restarted
    mem_req = 1'b1;
    tick(); tick(); tick();
    chk("rewait_no_to", 32'(mem_timeout), 32'd0);
    mem_ready = 1'b1;
    #1;
    chk_outs("rewait_release", O_RUN);
    tick();
    mem_req = 1'b0; mem_ready = 1'b0;

    // watchdog: 4 consecutive mwait cycles -> ERR
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick();
    mem_req = 1'b1;
    tick(); tick(); tick();
    chk("wd_before_trip", 32'(mem_timeout), 32'd0);
    tick();
    chk("wd_tripped", 32'(mem_timeout), 32'd1);
    chk("wd_cnt4", 32'(stall_cnt), 32'd4);
    mem_ready = 1'b1; ex_redirect = 1'b1;
    #1;
    chk_outs("err_frozen_ready", O_ZERO);
    tick();
    mem_req = 1'b0; mem_ready = 1'b0; ex_redirect = 1'b0;
    #1;
    chk_outs("err_frozen_idle", O_ZERO);
    tick();
    tick();
    chk("cnt_at_7", 32'(stall_cnt), 32'd7);
    tick();
    tick();
    chk("cnt_saturated", 32'(stall_cnt), 32'd7);
    chk("err_sticky", 32'(mem_timeout), 32'd1);

    rst = 1'b1;
    #1;
    chk("err_rst_to", 32'(mem_timeout), 32'd0);
    chk("err_rst_cnt", 32'(stall_cnt), 32'd0);
    rst = 1'b0;
    #1;
    chk_outs("err_rst_run", O_RUN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
